// File: rtl/pulse_crossing_arbiter.sv
// ============================================================================
// Module   : pulse_crossing_arbiter
// Brief    : Latches single-cycle request pulses from several fast-domain
//            requesters and shares one pulse channel among them. The winner
//            is driven as a pulse stretched to HOLD_CYCLES, then a guard gap.
//            Define PULSE_ARB_FIXED_PRIORITY_EN for lowest-index-wins
//            arbitration; the default is round robin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_crossing_arbiter #(
    parameter int REQUESTERS  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int ID_WIDTH    = $clog2(REQUESTERS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REQUESTERS-1:0] requests,
    output logic [REQUESTERS-1:0] pending,
    output logic                  pulseOut,
    output logic [ID_WIDTH-1:0]   channelId,
    output logic                  busy,
    output logic [REQUESTERS-1:0] dropped
);

    localparam int c_cnt_max = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max) + 1;

    localparam logic [c_cnt_w-1:0] c_hold_load = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load  = (GAP_CYCLES > 0) ? c_cnt_w'(GAP_CYCLES - 1) : '0;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_hold = 2'd1;
    localparam logic [1:0] c_gap  = 2'd2;

    logic [1:0]            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [REQUESTERS-1:0] r_pending;
    logic [REQUESTERS-1:0] r_dropped;
    logic [ID_WIDTH-1:0]   r_id;

    logic [1:0]            w_state_nxt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic                  w_found;
    logic                  w_grant;
    logic [ID_WIDTH-1:0]   w_winner;
    logic [ID_WIDTH-1:0]   w_idx;
    logic [REQUESTERS-1:0] w_gmask;

`ifdef PULSE_ARB_FIXED_PRIORITY_EN
    // Descending scan so the lowest pending index is the last one written.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            w_idx = ID_WIDTH'(k);
            if (r_pending[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end
`else
    localparam int c_sum_w = ID_WIDTH + 1;

    logic [ID_WIDTH-1:0] r_ptr;
    logic [c_sum_w-1:0]  w_sum;

    // Scan starts at the pointer and wraps; the first pending bit found wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        w_sum    = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            w_sum = {1'b0, r_ptr} + c_sum_w'(k);
            if (w_sum >= c_sum_w'(REQUESTERS)) begin
                w_sum = w_sum - c_sum_w'(REQUESTERS);
            end
            w_idx = w_sum[ID_WIDTH-1:0];
            if (!w_found && r_pending[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_winner == ID_WIDTH'(REQUESTERS - 1)) ? '0 : w_winner + 1'b1;
        end
    end
`endif

    assign w_grant = (r_state == c_idle) && w_found;
    assign w_gmask = w_grant ? (REQUESTERS'(1) << w_winner) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_idle: begin
                if (w_grant) begin
                    w_state_nxt = c_hold;
                    w_cnt_nxt   = c_hold_load;
                end
            end
            c_hold: begin
                if (r_cnt == '0) begin
                    w_state_nxt = (GAP_CYCLES == 0) ? c_idle : c_gap;
                    w_cnt_nxt   = c_gap_load;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_gap: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_idle;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A new request on the winner's own grant edge survives (set wins).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_pending <= '0;
            r_dropped <= '0;
            r_id      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pending <= (r_pending & ~w_gmask) | requests;
            r_dropped <= requests & r_pending & ~w_gmask;
            if (w_grant) begin
                r_id <= w_winner;
            end
        end
    end

    always_comb begin
        pulseOut  = (r_state == c_hold);
        busy      = (r_state != c_idle);
        pending   = r_pending;
        channelId = r_id;
        dropped   = r_dropped;
    end

endmodule

`default_nettype wire

// File: tb/tb_pulse_crossing_arbiter.sv
// ============================================================================
// Module   : tb_pulse_crossing_arbiter
// Brief    : Self-checking bench for pulse_crossing_arbiter (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_crossing_arbiter;

    localparam int N = 4;
    localparam int H = 8;
    localparam int G = 2;

    logic         clock;
    logic         reset;
    logic [N-1:0] requests;
    logic [N-1:0] pending;
    logic         pulseOut;
    logic [1:0]   channelId;
    logic         busy;
    logic [N-1:0] dropped;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending set, last grant cycle, next idle cycle, pointer.
    logic [N-1:0] m_pend;
    logic [N-1:0] m_drop;
    int           m_ptr;
    int           m_id;
    int           m_g;
    int           m_free;
    int           cyc;
    logic         prev_pulse;
    int           obs[$];
    int           obs_cyc[$];

    pulse_crossing_arbiter #(
        .REQUESTERS (N),
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .requests (requests),
        .pending  (pending),
        .pulseOut (pulseOut),
        .channelId(channelId),
        .busy     (busy),
        .dropped  (dropped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic e_pulse();
        return (cyc > m_g) && (cyc <= m_g + H);
    endfunction

    function automatic logic e_busy();
        return (cyc > m_g) && (cyc <= m_g + H + G);
    endfunction

    task automatic model_init();
        m_pend = '0; m_drop = '0; m_ptr = 0; m_id = 0;
        m_g = -1000; m_free = 0; cyc = 0; prev_pulse = 1'b0;
        obs.delete(); obs_cyc.delete();
    endtask

    task automatic apply_reset();
        requests = '0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_init();
    endtask

    // One clock: drive req for the current cycle, advance the model, sample #1 after the edge.
    task automatic drive_cycle(input logic [N-1:0] req);
        logic [N-1:0] gm;
        int w;
        requests = req;
        @(posedge clock);
        gm = '0;
        if (cyc >= m_free && m_pend != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
`ifdef PULSE_ARB_FIXED_PRIORITY_EN
                if (w < 0 && m_pend[k]) w = k;
`else
                if (w < 0 && m_pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
`endif
            end
            gm[w]  = 1'b1;
            m_id   = w;
            m_g    = cyc;
            m_free = cyc + H + G + 1;
            m_ptr  = (w + 1) % N;
        end
        m_drop = req & m_pend & ~gm;
        m_pend = (m_pend & ~gm) | req;
        cyc++;
        #1;
        requests = '0;
        if (pulseOut && !prev_pulse) begin
            obs.push_back(int'(channelId));
            obs_cyc.push_back(cyc);
        end
        prev_pulse = pulseOut;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        requests = '0;
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({pending, pulseOut, channelId, busy, dropped} !== '0) begin
            failures++;
            $display("FAIL reset_async: got pend=%b pulse=%b id=%0d busy=%b drop=%b, need all zero",
                     pending, pulseOut, channelId, busy, dropped);
        end
        apply_reset();
        #1;
        checks++;
        if ({pending, pulseOut, channelId, busy, dropped} !== '0) begin
            failures++;
            $display("FAIL reset_release: got pend=%b pulse=%b id=%0d busy=%b drop=%b, need all zero",
                     pending, pulseOut, channelId, busy, dropped);
        end
    endtask

    task automatic test_single();
        apply_reset();
        drive_cycle(4'b0010);
        while (cyc <= 14) begin
            checks++;
            if (pulseOut !== (cyc >= 2 && cyc <= 9)) begin
                failures++;
                $display("FAIL single_pulse cyc=%0d: got %b need %b", cyc, pulseOut, (cyc >= 2 && cyc <= 9));
            end
            checks++;
            if (busy !== (cyc >= 2 && cyc <= 11)) begin
                failures++;
                $display("FAIL single_busy cyc=%0d: got %b need %b", cyc, busy, (cyc >= 2 && cyc <= 11));
            end
            if (cyc >= 2) begin
                checks++;
                if (channelId !== 2'd1) begin
                    failures++;
                    $display("FAIL single_id cyc=%0d: got %0d need 1", cyc, channelId);
                end
            end
            drive_cycle(4'b0000);
        end
    endtask

    task automatic test_contention();
        apply_reset();
        drive_cycle(4'b1111);
        repeat (50) drive_cycle(4'b0000);
        checks++;
        if (obs.size() != 4) begin
            failures++;
            $display("FAIL contention_count: got %0d grants need 4", obs.size());
        end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            checks++;
            if (obs[i] != i || obs_cyc[i] != 2 + 11 * i) begin
                failures++;
                $display("FAIL contention_grant%0d: got id=%0d at cyc %0d need id=%0d at cyc %0d",
                         i, obs[i], obs_cyc[i], i, 2 + 11 * i);
            end
        end
    endtask

    task automatic test_fairness();
        int exp_id[4];
        int seen;
`ifdef PULSE_ARB_FIXED_PRIORITY_EN
        exp_id = '{0, 0, 0, 0};
`else
        exp_id = '{0, 2, 0, 2};
`endif
        apply_reset();
        drive_cycle(4'b0101);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (obs.size() != seen) begin
                seen = obs.size();
                drive_cycle(4'b0101);
            end else begin
                drive_cycle(4'b0000);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= obs.size() || obs[i] != exp_id[i]) begin
                failures++;
                $display("FAIL fairness_grant%0d: got %0d need %0d", i,
                         (i < obs.size()) ? obs[i] : -1, exp_id[i]);
            end
        end
    endtask

    task automatic test_coalesce_drop();
        logic [N-1:0] req;
        int n3;
        apply_reset();
        for (int k = 0; k < 50; k++) begin
            req = (k == 0) ? 4'b0001 : ((k == 3 || k == 6) ? 4'b1000 : 4'b0000);
            drive_cycle(req);
            if (cyc >= 4 && cyc <= 8) begin
                checks++;
                if (dropped !== ((cyc == 7) ? 4'b1000 : 4'b0000)) begin
                    failures++;
                    $display("FAIL drop_flag cyc=%0d: got %b need %b", cyc, dropped,
                             (cyc == 7) ? 4'b1000 : 4'b0000);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (pending !== 4'b1000) begin
                    failures++;
                    $display("FAIL drop_pending: got %b need 1000", pending);
                end
            end
        end
        n3 = 0;
        foreach (obs[i]) if (obs[i] == 3) n3++;
        checks++;
        if (n3 != 1 || obs.size() != 2) begin
            failures++;
            $display("FAIL drop_coalesce: got %0d grants to 3 of %0d total, need 1 of 2", n3, obs.size());
        end
    endtask

    task automatic test_set_wins();
        apply_reset();
        drive_cycle(4'b0010);
        drive_cycle(4'b0010);
        checks++;
        if (pending !== 4'b0010 || pulseOut !== 1'b1 || dropped !== 4'b0000) begin
            failures++;
            $display("FAIL setwins_state: got pend=%b pulse=%b drop=%b need 0010 1 0000",
                     pending, pulseOut, dropped);
        end
        repeat (30) drive_cycle(4'b0000);
        checks++;
        if (obs.size() != 2 || obs[0] != 1 || obs[1] != 1 || obs_cyc[1] != 13) begin
            failures++;
            $display("FAIL setwins_regrant: got %0d grants (second at cyc %0d), need two to id 1, second at 13",
                     obs.size(), (obs_cyc.size() > 1) ? obs_cyc[1] : -1);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        drive_cycle(4'b0001);
        drive_cycle(4'b0000);
        drive_cycle(4'b0100);
        while (cyc < 6) drive_cycle(4'b0000);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (pulseOut !== 1'b0 || busy !== 1'b0 || pending !== '0 || dropped !== '0 || channelId !== '0) begin
            failures++;
            $display("FAIL midreset_async: got pulse=%b busy=%b pend=%b drop=%b id=%0d need all zero",
                     pulseOut, busy, pending, dropped, channelId);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_init();
        drive_cycle(4'b0001);
        checks++;
        if (pulseOut !== 1'b0 || pending !== 4'b0001) begin
            failures++;
            $display("FAIL midreset_cyc1: got pulse=%b pend=%b need 0 0001", pulseOut, pending);
        end
        drive_cycle(4'b0000);
        checks++;
        if (pulseOut !== 1'b1 || channelId !== 2'd0 || pending !== 4'b0000) begin
            failures++;
            $display("FAIL midreset_cyc2: got pulse=%b id=%0d pend=%b need 1 0 0000",
                     pulseOut, channelId, pending);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        apply_reset();
        for (int k = 0; k < 500; k++) begin
            req = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            drive_cycle(req);
            checks++;
            if (pulseOut !== e_pulse()) begin
                failures++;
                if (failures < 40) $display("FAIL rand_pulse cyc=%0d: got %b need %b", cyc, pulseOut, e_pulse());
            end
            checks++;
            if (busy !== e_busy()) begin
                failures++;
                if (failures < 40) $display("FAIL rand_busy cyc=%0d: got %b need %b", cyc, busy, e_busy());
            end
            checks++;
            if (pending !== m_pend) begin
                failures++;
                if (failures < 40) $display("FAIL rand_pending cyc=%0d: got %b need %b", cyc, pending, m_pend);
            end
            checks++;
            if (dropped !== m_drop) begin
                failures++;
                if (failures < 40) $display("FAIL rand_dropped cyc=%0d: got %b need %b", cyc, dropped, m_drop);
            end
            checks++;
            if (int'(channelId) != m_id) begin
                failures++;
                if (failures < 40) $display("FAIL rand_id cyc=%0d: got %0d need %0d", cyc, channelId, m_id);
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        requests = '0;
        model_init();
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_coalesce_drop();
        test_set_wins();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
